// File: rtl/cla_addsub_pipe.sv
// cla_addsub_pipe: two-stage pipelined add/subtract unit built around a
// two-level carry look-ahead network (4-bit blocks plus a group lookahead).
// Stage 1 registers per-bit generate/propagate.
// Stage 2 resolves the carries and registers the sum and flags.
// Both sides use valid/ready handshakes with full backpressure.
// WIDTH must be a multiple of 4.
module cla_addsub_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op_sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int NB = WIDTH / 4;

  // Stage 1 registers
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_g;
  logic [WIDTH-1:0] r_p;
  logic             r_c0;
  logic             r_a_msb;
  logic             r_b_msb;

  // Stage 2 (output) registers
  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_neg;

  // Handshake and operand conditioning
  logic             w_s2_take;
  logic             w_accept;
  logic [WIDTH-1:0] w_beff;
  logic             w_c0;

  // Carry network
  logic [NB-1:0]    w_bg;
  logic [NB-1:0]    w_bp;
  logic [NB:0]      w_bc;
  logic [WIDTH-1:0] w_c;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;

  // Handshake: out_ready reaches in_ready combinationally through w_s2_take.
  always_comb begin
    w_s2_take = ~r_out_valid | out_ready;
    in_ready  = ~flush & (~r_s1_valid | w_s2_take);
    w_accept  = in_valid & in_ready;
  end

  // Operand conditioning: subtraction is A + ~B + 1.
  always_comb begin
    w_beff = op_sub ? ~b : b;
    w_c0   = op_sub | cin;
  end

  // Stage 1: capture generate/propagate on accept; flush empties the stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_g        <= '0;
      r_p        <= '0;
      r_c0       <= 1'b0;
      r_a_msb    <= 1'b0;
      r_b_msb    <= 1'b0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_g        <= a & w_beff;
      r_p        <= a ^ w_beff;
      r_c0       <= w_c0;
      r_a_msb    <= a[WIDTH-1];
      r_b_msb    <= w_beff[WIDTH-1];
    end else if (w_s2_take) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Block-level generate/propagate for each 4-bit block.
  always_comb begin
    logic [3:0] gb;
    logic [3:0] pb;
    w_bg = '0;
    w_bp = '0;
    for (int unsigned k = 0; k < NB; k++) begin
      gb = r_g[4*k +: 4];
      pb = r_p[4*k +: 4];
      w_bg[k] = gb[3]
              | (pb[3] & gb[2])
              | (pb[3] & pb[2] & gb[1])
              | (pb[3] & pb[2] & pb[1] & gb[0]);
      w_bp[k] = &pb;
    end
  end

  // Group lookahead: each block carry-in as a flat sum of products over the
  // lower blocks' G/P and c0, so no carry ripples from block to block.
  always_comb begin
    logic acc;
    logic pp;
    w_bc    = '0;
    w_bc[0] = r_c0;
    for (int unsigned k = 0; k < NB; k++) begin
      acc = 1'b0;
      pp  = 1'b1;
      for (int unsigned j = 0; j <= k; j++) begin
        acc = acc | (pp & w_bg[k-j]);
        pp  = pp & w_bp[k-j];
      end
      w_bc[k+1] = acc | (pp & r_c0);
    end
  end

  // Bit carries inside each block, looked ahead from the block carry-in.
  always_comb begin
    logic [3:0] gb;
    logic [3:0] pb;
    logic       c;
    w_c = '0;
    for (int unsigned k = 0; k < NB; k++) begin
      gb = r_g[4*k +: 4];
      pb = r_p[4*k +: 4];
      c  = w_bc[k];
      w_c[4*k]   = c;
      w_c[4*k+1] = gb[0] | (pb[0] & c);
      w_c[4*k+2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & c);
      w_c[4*k+3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
                 | (pb[2] & pb[1] & pb[0] & c);
    end
  end

  // Sum and flags from the resolved carries.
  always_comb begin
    w_sum  = r_p ^ w_c;
    w_cout = w_bc[NB];
    w_ovf  = (r_a_msb == r_b_msb) & (w_sum[WIDTH-1] != r_a_msb);
  end

  // Stage 2: advance when the output slot is free or being consumed;
  // on a stall every output register holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_s2_take) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_sum  <= w_sum;
        r_cout <= w_cout;
        r_ovf  <= w_ovf;
        r_zero <= (w_sum == '0);
        r_neg  <= w_sum[WIDTH-1];
      end
    end
  end

  // Output drive
  always_comb begin
    out_valid = r_out_valid;
    sum       = r_sum;
    cout      = r_cout;
    ovf       = r_ovf;
    zero      = r_zero;
    neg       = r_neg;
  end

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Testbench for cla_addsub_pipe: scoreboard of expected results fed at
// accept time, monitor comparing on every cycle the result is presented.
module tb_cla_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        op_sub = 1'b0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] sum;
  logic        cout, ovf, zero, neg;

  cla_addsub_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op_sub(op_sub), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
    int unsigned acc;
  } exp_t;

  exp_t        q[$];
  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc = 0;
  int unsigned pops = 0;
  bit          done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [32:0] got, input logic [32:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic o, input logic c);
    exp_t        e;
    logic [31:0] be;
    logic [32:0] r;
    longint      s;
    be = o ? ~y : y;
    r  = {1'b0, x} + {1'b0, be} + {32'd0, (o | c)};
    s  = longint'($signed(x)) + longint'($signed(be)) + longint'(o | c);
    e.sum  = r[31:0];
    e.cout = r[32];
    e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    e.zero = (r[31:0] == 32'd0);
    e.neg  = r[31];
    e.acc  = 0;
    return e;
  endfunction

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    logic exp_ir, exp_ov;
    if (!rst_n) begin
      chk("rst_out_valid", {32'd0, out_valid}, 33'd0);
      q.delete();
    end else begin
      exp_ir = !flush && (q.size() < 2 || out_ready);
      exp_ov = (q.size() > 0) && (cyc > q[0].acc);
      chk("in_ready", {32'd0, in_ready}, {32'd0, exp_ir});
      chk("out_valid", {32'd0, out_valid}, {32'd0, exp_ov});
      if (out_valid && q.size() > 0) begin
        chk("sum_cout", {cout, sum}, {q[0].cout, q[0].sum});
        chk("flags", {30'd0, ovf, zero, neg}, {30'd0, q[0].ovf, q[0].zero, q[0].neg});
        if (out_ready) begin
          void'(q.pop_front());
          pops++;
        end
      end
      if (flush) q.delete();
      else if (in_valid && exp_ir) begin
        e = model(a, b, op_sub, cin);
        e.acc = cyc + 1;
        q.push_back(e);
      end
    end
  end

  // Present a beat from posedge+1 and hold it until it is accepted.
  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic o, input logic c);
    int unsigned n = 0;
    bit taken = 0;
    in_valid = 1'b1; a = x; b = y; op_sub = o; cin = c;
    while (!taken && n < 200) begin
      @(negedge clk);
      taken = rst_n && !flush && in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!taken) chk("send_timeout", 33'd0, 33'd1);
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom % 8)
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned p0;
    // 1. reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", {32'd0, in_ready}, 33'd1);
    chk("reset_out_valid", {32'd0, out_valid}, 33'd0);
    chk("reset_sum", {cout, sum}, 33'd0);
    chk("reset_flags", {30'd0, ovf, zero, neg}, 33'd0);
    @(posedge clk); #1;

    // 2. all-ones + 1
    send(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    @(posedge clk); @(negedge clk);
    chk("t2_valid", {32'd0, out_valid}, 33'd1);
    chk("t2_sum", {cout, sum}, {1'b1, 32'd0});
    chk("t2_flags", {30'd0, ovf, zero, neg}, {30'd0, 3'b010});
    @(posedge clk); #1;

    // 3. signed overflow and subtraction with borrow
    send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
    @(posedge clk); @(negedge clk);
    chk("t3a_sum", {cout, sum}, {1'b0, 32'h8000_0000});
    chk("t3a_flags", {30'd0, ovf, zero, neg}, {30'd0, 3'b101});
    @(posedge clk); #1;
    send(32'd5, 32'd7, 1'b1, 1'b0);
    @(posedge clk); @(negedge clk);
    chk("t3b_sum", {cout, sum}, {1'b0, 32'hFFFF_FFFE});
    chk("t3b_flags", {30'd0, ovf, zero, neg}, {30'd0, 3'b001});
    @(posedge clk); #1;

    // 4. eight back-to-back beats with a stall window
    p0 = pops;
    fork
      for (int i = 0; i < 8; i++) send(32'h1000_0000 * i + 32'd3, 32'd11 * i, i[0], i[1]);
      begin
        for (int c = 0; c < 12; c++) begin
          out_ready = !(c >= 3 && c <= 6);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk); #1;
    chk("t4_count", 33'(pops - p0), 33'd8);

    // 5. flush with both stages full and a beat presented
    out_ready = 1'b0;
    send(32'd100, 32'd1, 1'b0, 1'b0);
    send(32'd200, 32'd2, 1'b0, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b1; a = 32'd300; b = 32'd3; op_sub = 1'b0; cin = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    chk("t5_ready_during_flush", {32'd0, in_ready}, 33'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("t5_out_valid", {32'd0, out_valid}, 33'd0);
    chk("t5_in_ready", {32'd0, in_ready}, 33'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("t5_next_sum", {cout, sum}, {1'b0, 32'd303});
    @(posedge clk); #1;

    // 6. random traffic with random backpressure, flushes and resets
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom % 8 == 0) begin
            @(posedge clk); #1;
          end
          if ($urandom % 600 == 0) begin
            #2 rst_n = 1'b0;
            @(negedge clk); #2 rst_n = 1'b1;
            @(posedge clk); #1;
          end
          send(rnd_op(), rnd_op(), 1'($urandom), 1'($urandom));
        end
        done = 1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom % 4) != 0;
          flush = ($urandom % 50) == 0;
          @(posedge clk); #1;
        end
        flush = 1'b0;
        out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", 33'(q.size()), 33'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
